fetch_unit: RTL and testbench

Instruction fetch stage. Generates the PC and issues single-outstanding read cycles on the instruction bus port. It presents each fetched word, with its PC, to the decode stage through a valid/stall handshake. It also handles branch/jump/trap redirects and reports fetch faults so decode can raise an exception.

---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, one outstanding bus read at a time,
// valid/stall handoff to decode, redirects and fault reporting. Option: FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR     = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] iport_addr_o,
    output logic        iport_cyc_o,
    output logic        iport_stb_o,
    input  logic [31:0] iport_data_i,
    input  logic        iport_ack_i,
    input  logic        iport_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        stall_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        fetch_fault_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD,
        FAULT
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] pending_pc, pending_next;
    logic [31:0] instr_q, instr_next;
    logic [31:0] pc_q, pc_next;
    logic        valid_q, valid_next;
    logic        fault_q, fault_next;

    logic        bus_done;
    logic        wait_hit;
    logic        goto_target;
    logic [31:0] target;

    assign bus_done = iport_ack_i | iport_err_i;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt, wait_next;

    assign wait_hit = (wait_cnt == WAIT_LAST) && !bus_done;

    // Count only while the same bus cycle keeps waiting; any exit or re-entry clears.
    always_comb begin
        wait_next = 16'd0;
        if ((state == FETCH) && !bus_done && !redirect_i && !wait_hit)
            wait_next = wait_cnt + 16'd1;
        else if ((state == DISCARD) && !bus_done && !wait_hit)
            wait_next = wait_cnt + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            wait_cnt <= 16'd0;
        else
            wait_cnt <= wait_next;
    end
`else
    // Timeout disabled: the bus cycle waits for ack/err indefinitely.
    assign wait_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        pending_next  = pending_pc;
        instr_next    = instr_q;
        pc_next       = pc_q;
        valid_next    = valid_q;
        fault_next    = fault_q;
        goto_target   = 1'b0;
        target        = redirect_addr_i;

        if (redirect_i) begin
            case (state)
                FETCH: begin
                    if (bus_done) begin
                        goto_target = 1'b1;
                    end else begin
                        pending_next = redirect_addr_i;
                        state_next   = DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus_done)
                        goto_target = 1'b1;
                    else
                        pending_next = redirect_addr_i;
                end
                default: goto_target = 1'b1;
            endcase
        end else begin
            case (state)
                IDLE: state_next = FETCH;
                FETCH: begin
                    if (iport_ack_i) begin
                        instr_next = iport_data_i;
                        pc_next    = fetch_pc;
                        valid_next = 1'b1;
                        fault_next = 1'b0;
                        state_next = HOLD;
                    end else if (iport_err_i || wait_hit) begin
                        instr_next = NOP;
                        pc_next    = fetch_pc;
                        valid_next = 1'b1;
                        fault_next = 1'b1;
                        state_next = FAULT;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        valid_next    = 1'b0;
                        state_next    = FETCH;
                    end
                end
                DISCARD: begin
                    if (bus_done || wait_hit) begin
                        goto_target = 1'b1;
                        target      = pending_pc;
                    end
                end
                default: state_next = state;
            endcase
        end

        // A misaligned target never reaches the bus; it becomes a fault entry.
        if (goto_target) begin
            if (target[1:0] != 2'b00) begin
                instr_next = NOP;
                pc_next    = target;
                valid_next = 1'b1;
                fault_next = 1'b1;
                state_next = FAULT;
            end else begin
                fetch_pc_next = target;
                valid_next    = 1'b0;
                fault_next    = 1'b0;
                state_next    = FETCH;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            fetch_pc   <= RESET_ADDR;
            pending_pc <= RESET_ADDR;
            instr_q    <= NOP;
            pc_q       <= RESET_ADDR;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            pending_pc <= pending_next;
            instr_q    <= instr_next;
            pc_q       <= pc_next;
            valid_q    <= valid_next;
            fault_q    <= fault_next;
        end
    end

    // During DISCARD the address stays on the abandoned cycle until it terminates.
    assign iport_addr_o  = fetch_pc;
    assign iport_cyc_o   = (state == FETCH) || (state == DISCARD);
    assign iport_stb_o   = iport_cyc_o;
    assign instruction_o = instr_q;
    assign pc_o          = pc_q;
    assign valid_o       = valid_q;
    assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, stall, redirect/discard, faults, reset, timeout.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] iport_addr_o;
    logic        iport_cyc_o;
    logic        iport_stb_o;
    logic [31:0] iport_data_i;
    logic        iport_ack_i;
    logic        iport_err_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        stall_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        fetch_fault_o;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .iport_addr_o    (iport_addr_o),
        .iport_cyc_o     (iport_cyc_o),
        .iport_stb_o     (iport_stb_o),
        .iport_data_i    (iport_data_i),
        .iport_ack_i     (iport_ack_i),
        .iport_err_i     (iport_err_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .stall_i         (stall_i),
        .instruction_o   (instruction_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .fetch_fault_o   (fetch_fault_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        logic ok;
        rst_i = 1'b1; iport_data_i = '0; iport_ack_i = 0; iport_err_i = 0;
        redirect_i = 0; redirect_addr_i = '0; stall_i = 0;
        step(); step();
        chk("rst_stb",   {31'd0, iport_stb_o},   32'd0);
        chk("rst_cyc",   {31'd0, iport_cyc_o},   32'd0);
        chk("rst_addr",  iport_addr_o,           32'h8000_0000);
        chk("rst_instr", instruction_o,          32'h0000_0013);
        chk("rst_pc",    pc_o,                   32'h8000_0000);
        chk("rst_valid", {31'd0, valid_o},       32'd0);
        chk("rst_fault", {31'd0, fetch_fault_o}, 32'd0);

        // Zero-wait fetch from reset address
        rst_i = 0;
        step();
        chk("t1_stb",  {31'd0, iport_stb_o}, 32'd1);
        chk("t1_addr", iport_addr_o,         32'h8000_0000);
        chk("t1_vld0", {31'd0, valid_o},     32'd0);
        iport_ack_i = 1; iport_data_i = 32'h0050_0093;
        step();
        iport_ack_i = 0; iport_data_i = '0;
        chk("t1_valid", {31'd0, valid_o},     32'd1);
        chk("t1_instr", instruction_o,        32'h0050_0093);
        chk("t1_pc",    pc_o,                 32'h8000_0000);
        chk("t1_stb0",  {31'd0, iport_stb_o}, 32'd0);
        step();
        chk("t1_next_stb",  {31'd0, iport_stb_o}, 32'd1);
        chk("t1_next_addr", iport_addr_o,         32'h8000_0004);
        chk("t1_next_vld",  {31'd0, valid_o},     32'd0);

        // Stall in HOLD for three cycles
        iport_ack_i = 1; iport_data_i = 32'h0010_0113;
        step();
        iport_ack_i = 0; stall_i = 1;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!(valid_o === 1'b1 && instruction_o === 32'h0010_0113 &&
                  pc_o === 32'h8000_0004 && iport_stb_o === 1'b0)) ok = 1'b0;
        end
        chk("t2_stall_frozen", {31'd0, ok}, 32'd1);
        stall_i = 0;
        step();
        chk("t2_valid", {31'd0, valid_o},     32'd0);
        chk("t2_stb",   {31'd0, iport_stb_o}, 32'd1);
        chk("t2_addr",  iport_addr_o,         32'h8000_0008);

        // Redirect mid-fetch: old cycle discarded
        redirect_i = 1; redirect_addr_i = 32'h8000_0100;
        step();
        redirect_i = 0;
        chk("t3_disc_stb",  {31'd0, iport_stb_o}, 32'd1);
        chk("t3_disc_addr", iport_addr_o,         32'h8000_0008);
        chk("t3_disc_vld",  {31'd0, valid_o},     32'd0);
        step();
        chk("t3_disc_addr2", iport_addr_o, 32'h8000_0008);
        iport_ack_i = 1; iport_data_i = 32'hDEAD_BEEF;
        step();
        iport_ack_i = 0;
        chk("t3_new_stb",  {31'd0, iport_stb_o}, 32'd1);
        chk("t3_new_addr", iport_addr_o,         32'h8000_0100);
        chk("t3_new_vld",  {31'd0, valid_o},     32'd0);
        iport_ack_i = 1; iport_data_i = 32'h0000_0033;
        step();
        iport_ack_i = 0;
        chk("t3_instr", instruction_o, 32'h0000_0033);
        chk("t3_pc",    pc_o,          32'h8000_0100);

        // Misaligned redirect from HOLD
        redirect_i = 1; redirect_addr_i = 32'h8000_0102;
        step();
        redirect_i = 0;
        chk("t4_stb",   {31'd0, iport_stb_o},   32'd0);
        chk("t4_valid", {31'd0, valid_o},       32'd1);
        chk("t4_fault", {31'd0, fetch_fault_o}, 32'd1);
        chk("t4_pc",    pc_o,                   32'h8000_0102);
        chk("t4_instr", instruction_o,          32'h0000_0013);
        stall_i = 1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(valid_o === 1'b1 && fetch_fault_o === 1'b1 && pc_o === 32'h8000_0102 &&
                  iport_stb_o === 1'b0)) ok = 1'b0;
        end
        chk("t4_fault_held", {31'd0, ok}, 32'd1);
        stall_i = 0; redirect_i = 1; redirect_addr_i = 32'h8000_0200;
        step();
        redirect_i = 0;
        chk("t4_out_stb",   {31'd0, iport_stb_o},   32'd1);
        chk("t4_out_addr",  iport_addr_o,           32'h8000_0200);
        chk("t4_out_fault", {31'd0, fetch_fault_o}, 32'd0);
        chk("t4_out_vld",   {31'd0, valid_o},       32'd0);

        // Redirect with simultaneous ack: response dropped, fetch at target
        redirect_i = 1; redirect_addr_i = 32'h8000_0010;
        iport_ack_i = 1; iport_data_i = 32'h1234_5678;
        step();
        redirect_i = 0; iport_ack_i = 0;
        chk("t5_sim_addr", iport_addr_o,     32'h8000_0010);
        chk("t5_sim_vld",  {31'd0, valid_o}, 32'd0);

        // Bus error -> fault at fetch pc
        iport_err_i = 1;
        step();
        iport_err_i = 0;
        chk("t5_err_fault", {31'd0, fetch_fault_o}, 32'd1);
        chk("t5_err_pc",    pc_o,                   32'h8000_0010);
        chk("t5_err_stb",   {31'd0, iport_stb_o},   32'd0);
        redirect_i = 1; redirect_addr_i = 32'h8000_0300;
        step();
        redirect_i = 0;
        chk("t5_redir_addr", iport_addr_o, 32'h8000_0300);

        // Reset mid-fetch with a coincident ack that must be ignored
        rst_i = 1; iport_ack_i = 1; iport_data_i = 32'hCAFE_F00D;
        step();
        iport_ack_i = 0;
        chk("t5_rst_stb",   {31'd0, iport_stb_o}, 32'd0);
        chk("t5_rst_vld",   {31'd0, valid_o},     32'd0);
        chk("t5_rst_instr", instruction_o,        32'h0000_0013);
        rst_i = 0;
        step();
        chk("t5_restart_stb",  {31'd0, iport_stb_o}, 32'd1);
        chk("t5_restart_addr", iport_addr_o,         32'h8000_0000);

`ifdef FETCH_TIMEOUT_EN
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (iport_stb_o !== 1'b1) ok = 1'b0;
        end
        chk("t6_stb_16", {31'd0, ok}, 32'd1);
        step();
        chk("t6_to_stb",   {31'd0, iport_stb_o},   32'd0);
        chk("t6_to_fault", {31'd0, fetch_fault_o}, 32'd1);
        chk("t6_to_pc",    pc_o,                   32'h8000_0000);
`else
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (iport_stb_o !== 1'b1) ok = 1'b0;
        end
        chk("t6_no_timeout", {31'd0, ok},            32'd1);
        chk("t6_no_fault",   {31'd0, fetch_fault_o}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
